// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: opcodes, FSM states,
// access sizes and the alignment rule.
package lsu_pkg;

    typedef enum logic [2:0] {
        OpLb  = 3'd0,
        OpLh  = 3'd1,
        OpLw  = 3'd2,
        OpLbu = 3'd3,
        OpLhu = 3'd4,
        OpSb  = 3'd5,
        OpSh  = 3'd6,
        OpSw  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } lsu_state_e;

    typedef enum logic [1:0] {
        SzByte,
        SzHalf,
        SzWord
    } lsu_size_e;

    function automatic lsu_size_e op_size(lsu_op_e op);
        case (op)
            OpLb, OpLbu, OpSb: return SzByte;
            OpLh, OpLhu, OpSh: return SzHalf;
            default:           return SzWord;
        endcase
    endfunction

    function automatic logic is_store(lsu_op_e op);
        return (op == OpSb) || (op == OpSh) || (op == OpSw);
    endfunction

    function automatic logic is_aligned(lsu_op_e op, logic [1:0] addr_lo);
        case (op_size(op))
            SzByte:  return 1'b1;
            SzHalf:  return ~addr_lo[0];
            default: return addr_lo == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_store_seq_if.sv
// Memory-side request/acknowledge bus of the load/store sequencer.
interface load_store_seq_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    MemReq;
    logic                    MemWE;
    logic [ADDR_WIDTH-1:0]   MemAddr;
    logic [DATA_WIDTH/8-1:0] MemByteEn;
    logic [DATA_WIDTH-1:0]   MemWData;
    logic                    MemAck;
    logic [DATA_WIDTH-1:0]   MemRData;

    modport master (
        output MemReq, MemWE, MemAddr, MemByteEn, MemWData,
        input  MemAck, MemRData
    );

    modport slave (
        input  MemReq, MemWE, MemAddr, MemByteEn, MemWData,
        output MemAck, MemRData
    );
endinterface

// File: rtl/load_extend.sv
// Picks the addressed lane(s) out of a memory word and sign/zero-extends them
// to the full data width according to the load opcode.
module load_extend
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]             rdata,
    input  logic [$clog2(DATA_WIDTH/8)-1:0]   lane,
    input  lsu_op_e                           op,
    output logic [DATA_WIDTH-1:0]             result
);
    localparam int unsigned LaneW = $clog2(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        result  = '0;
        // Sized casts of signed operands sign-extend; of unsigned, zero-extend.
        case (op)
            OpLb:    result = DATA_WIDTH'($signed(shifted[7:0]));
            OpLh:    result = DATA_WIDTH'($signed(shifted[15:0]));
            OpLw:    result = DATA_WIDTH'($signed(shifted[31:0]));
            OpLbu:   result = DATA_WIDTH'(shifted[7:0]);
            OpLhu:   result = DATA_WIDTH'(shifted[15:0]);
            default: result = '0;
        endcase
    end

    logic unused_lane_w;
    assign unused_lane_w = (LaneW == 0);

endmodule

// File: rtl/load_store_seq.sv
// Single-outstanding load/store sequencer: computes the effective address,
// checks alignment, runs one memory handshake with timeout and extends loads.
module load_store_seq
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [2:0]            LoadStoreControl,
    input  logic [ADDR_WIDTH-1:0] SrcA,
    input  logic [ADDR_WIDTH-1:0] Imm,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic                  ErrMisalign,
    output logic [DATA_WIDTH-1:0] LoadResult,
    load_store_seq_if.master      mem
);
    localparam int unsigned NumLanes = DATA_WIDTH / 8;
    localparam int unsigned LaneW    = $clog2(NumLanes);
    localparam int unsigned CntW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_e state_q, state_d;

    lsu_op_e               op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [CntW-1:0]       cnt_q;
    logic                  err_q;
    logic                  misalign_q;
    logic [DATA_WIDTH-1:0] load_result_q;

    lsu_op_e               start_op;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic                  start_aligned;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] ext_data;
    logic [NumLanes-1:0]   size_mask;

    assign start_op      = lsu_op_e'(LoadStoreControl);
    assign eff_addr      = SrcA + Imm;
    assign start_aligned = is_aligned(start_op, eff_addr[1:0]);
    assign timeout_hit   = (cnt_q == CntW'(TIMEOUT - 1));

    load_extend #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_extend (
        .rdata  (mem.MemRData),
        .lane   (addr_q[LaneW-1:0]),
        .op     (op_q),
        .result (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = start_aligned ? StAccess : StDone;
                end
            end
            StAccess: begin
                if (mem.MemAck || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= OpLb;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            err_q         <= 1'b0;
            misalign_q    <= 1'b0;
            load_result_q <= '0;
        end else begin
            if (state_q == StIdle && Start) begin
                op_q       <= start_op;
                addr_q     <= eff_addr;
                wdata_q    <= WriteData[31:0];
                cnt_q      <= '0;
                err_q      <= ~start_aligned;
                misalign_q <= ~start_aligned;
            end
            if (state_q == StAccess) begin
                // Ack wins over a timeout firing in the same cycle.
                if (mem.MemAck) begin
                    if (!is_store(op_q)) begin
                        load_result_q <= ext_data;
                    end
                end else if (timeout_hit) begin
                    err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end

    always_comb begin
        size_mask = '0;
        case (op_size(op_q))
            SzByte:  size_mask = NumLanes'(1);
            SzHalf:  size_mask = NumLanes'(3);
            default: size_mask = NumLanes'(15);
        endcase
    end

    // Bus outputs are forced to zero outside ACCESS so reset drops them at once.
    always_comb begin
        Busy          = (state_q != StIdle);
        Done          = (state_q == StDone);
        Error         = Done & err_q;
        ErrMisalign   = Done & misalign_q;
        LoadResult    = load_result_q;
        mem.MemReq    = 1'b0;
        mem.MemWE     = 1'b0;
        mem.MemAddr   = '0;
        mem.MemByteEn = '0;
        mem.MemWData  = '0;
        if (state_q == StAccess) begin
            mem.MemReq    = 1'b1;
            mem.MemWE     = is_store(op_q);
            mem.MemAddr   = {addr_q[ADDR_WIDTH-1:LaneW], LaneW'(0)};
            mem.MemByteEn = size_mask << addr_q[LaneW-1:0];
            case (op_size(op_q))
                SzByte:  mem.MemWData = {NumLanes{wdata_q[7:0]}};
                SzHalf:  mem.MemWData = {(NumLanes / 2){wdata_q[15:0]}};
                default: mem.MemWData = {(NumLanes / 4){wdata_q[31:0]}};
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_seq.sv
// Randomised and directed checks of load_store_seq against a behavioural model.
module tb_load_store_seq;
    import lsu_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          Start;
    logic [2:0]    LoadStoreControl;
    logic [AW-1:0] SrcA;
    logic [AW-1:0] Imm;
    logic [DW-1:0] WriteData;
    logic          Busy;
    logic          Done;
    logic          Error;
    logic          ErrMisalign;
    logic [DW-1:0] LoadResult;

    load_store_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem ();

    load_store_seq #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .Start            (Start),
        .LoadStoreControl (LoadStoreControl),
        .SrcA             (SrcA),
        .Imm              (Imm),
        .WriteData        (WriteData),
        .Busy             (Busy),
        .Done             (Done),
        .Error            (Error),
        .ErrMisalign      (ErrMisalign),
        .LoadResult       (LoadResult),
        .mem              (mem)
    );

    int          checks   = 0;
    int          errors   = 0;
    logic [31:0] model_lr = 32'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] op, input int lane,
                                               input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * lane);
        case (op)
            3'd0:    return v[7]  ? ((v & 32'hFF) | 32'hFFFF_FF00) : (v & 32'hFF);
            3'd1:    return v[15] ? ((v & 32'hFFFF) | 32'hFFFF_0000) : (v & 32'hFFFF);
            3'd2:    return v;
            3'd3:    return v & 32'hFF;
            3'd4:    return v & 32'hFFFF;
            default: return model_lr;
        endcase
    endfunction

    // ack_delay: index of the ACCESS cycle carrying MemAck; negative means never.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] wd, input logic [31:0] rd, input int ack_delay,
                          input bit busy_start);
        logic [31:0] ea;
        logic [31:0] wrep;
        logic [3:0]  be;
        int          nb;
        int          lane;
        int          req_cycles;
        bit          aligned;
        bit          acked;
        bit          store;
        ea      = a + b;
        nb      = (op == 3'd0 || op == 3'd3 || op == 3'd5) ? 1 :
                  (op == 3'd1 || op == 3'd4 || op == 3'd6) ? 2 : 4;
        lane    = int'(ea % 4);
        aligned = (ea % nb) == 0;
        store   = op >= 3'd5;
        be      = 4'(((1 << nb) - 1) << lane);
        wrep    = (nb == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                  (nb == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
        acked      = ack_delay >= 0 && ack_delay < int'(TO);
        req_cycles = acked ? ack_delay + 1 : int'(TO);

        Start            = 1'b1;
        LoadStoreControl = op;
        SrcA             = a;
        Imm              = b;
        WriteData        = wd;
        mem.MemAck       = 1'($urandom_range(0, 1));
        mem.MemRData     = $urandom;
        tick();
        Start            = busy_start;
        LoadStoreControl = 3'($urandom);
        SrcA             = $urandom;
        Imm              = $urandom;
        WriteData        = $urandom;

        if (!aligned) begin
            check_eq("mis_req", mem.MemReq, 1'b0);
            check_eq("mis_done", Done, 1'b1);
            check_eq("mis_err", Error, 1'b1);
            check_eq("mis_cause", ErrMisalign, 1'b1);
            check_eq("mis_lr", LoadResult, model_lr);
        end else begin
            for (int n = 0; n < req_cycles; n++) begin
                check_eq("acc_req", mem.MemReq, 1'b1);
                check_eq("acc_busy", Busy, 1'b1);
                check_eq("acc_done", Done, 1'b0);
                check_eq("acc_addr", mem.MemAddr, {ea[31:2], 2'b00});
                check_eq("acc_be", 32'(mem.MemByteEn), 32'(be));
                check_eq("acc_we", mem.MemWE, store);
                if (store) check_eq("acc_wdata", mem.MemWData, wrep);
                mem.MemAck   = acked && (n == ack_delay);
                mem.MemRData = mem.MemAck ? rd : $urandom;
                tick();
            end
            mem.MemAck   = 1'($urandom_range(0, 1));
            mem.MemRData = $urandom;
            if (acked && !store) model_lr = model_load(op, lane, rd);
            check_eq("fin_done", Done, 1'b1);
            check_eq("fin_req", mem.MemReq, 1'b0);
            check_eq("fin_err", Error, !acked);
            check_eq("fin_cause", ErrMisalign, 1'b0);
            check_eq("fin_lr", LoadResult, model_lr);
        end
        tick();
        Start      = 1'b0;
        mem.MemAck = 1'b0;
        check_eq("idle_busy", Busy, 1'b0);
        check_eq("idle_done", Done, 1'b0);
        check_eq("idle_lr", LoadResult, model_lr);
        if (busy_start) begin
            tick();
            check_eq("no_second_req", mem.MemReq, 1'b0);
            check_eq("no_second_busy", Busy, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        Start            = 1'b0;
        LoadStoreControl = 3'd0;
        SrcA             = '0;
        Imm              = '0;
        WriteData        = '0;
        mem.MemAck       = 1'b0;
        mem.MemRData     = '0;
        #12;
        check_eq("rst_busy", Busy, 1'b0);
        check_eq("rst_done", Done, 1'b0);
        check_eq("rst_err", Error, 1'b0);
        check_eq("rst_cause", ErrMisalign, 1'b0);
        check_eq("rst_req", mem.MemReq, 1'b0);
        check_eq("rst_we", mem.MemWE, 1'b0);
        check_eq("rst_lr", LoadResult, 32'h0);
        check_eq("rst_addr", mem.MemAddr, 32'h0);
        check_eq("rst_be", 32'(mem.MemByteEn), 32'h0);
        check_eq("rst_wdata", mem.MemWData, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // lb sign case, lhu with wrap, sh with delayed ack, misaligned lw
        run_op(3'd0, 32'h0000_0100, 32'd3, 32'h0, 32'h80FF_FF00, 0, 1'b0);
        check_eq("lb_result", LoadResult, 32'hFFFF_FF80);
        run_op(3'd4, 32'hFFFF_FFFE, 32'd4, 32'h0, 32'hBEEF_1234, 0, 1'b0);
        check_eq("lhu_result", LoadResult, 32'h0000_BEEF);
        run_op(3'd6, 32'h0000_0200, 32'd2, 32'h1234_ABCD, 32'h0, 3, 1'b0);
        check_eq("sh_lr_kept", LoadResult, 32'h0000_BEEF);
        run_op(3'd2, 32'h0000_0101, 32'd0, 32'h0, 32'h0, 0, 1'b0);

        // timeout, then ack in the last allowed cycle
        run_op(3'd2, 32'h0000_0400, 32'd0, 32'h0, 32'h1111_2222, -1, 1'b0);
        run_op(3'd2, 32'h0000_0400, 32'd4, 32'h0, 32'h3333_4444, 3, 1'b0);
        check_eq("ack_prio_lr", LoadResult, 32'h3333_4444);

        // Start pulsed while busy
        run_op(3'd7, 32'h0000_0800, 32'd0, 32'hCAFE_F00D, 32'h0, 2, 1'b1);

        // reset in the middle of an access
        Start            = 1'b1;
        LoadStoreControl = 3'd2;
        SrcA             = 32'h0000_0300;
        Imm              = 32'h0;
        tick();
        Start = 1'b0;
        check_eq("mid_req_before", mem.MemReq, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("mid_req_dropped", mem.MemReq, 1'b0);
        check_eq("mid_busy", Busy, 1'b0);
        check_eq("mid_lr", LoadResult, 32'h0);
        model_lr = 32'h0;
        tick();
        rst = 1'b0;
        check_eq("mid_done0", Done, 1'b0);
        tick();
        check_eq("mid_done1", Done, 1'b0);
        check_eq("mid_idle", Busy, 1'b0);

        for (int i = 0; i < 60; i++) begin
            d = int'($urandom_range(0, 5));
            if (d == 5) d = -1;
            run_op(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1) ? $urandom : 32'd0,
                   $urandom, $urandom, d, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_seq.md
LOAD_STORE_SEQ -- requirements
Module: load_store_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the memory data and register width; only 32 and 64 are legal.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning the byte address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles MemReq is held without MemAck.
REQ-004 SHALL use one clock, `clk  in  1`, with all state updated on its rising edge.
REQ-005 SHALL use reset `rst  in  1`, which is asynchronous and active-high.
REQ-006 Port list:
- `Start  in  1`: request a new access.
- `LoadStoreControl  in  3`: operation code.
- `SrcA  in  ADDR_WIDTH`: base address.
- `Imm  in  ADDR_WIDTH`: offset.
- `WriteData  in  DATA_WIDTH`: store data, least-significant-aligned.
- `Busy  out  1`: operation in flight.
- `Done  out  1`: one-cycle completion pulse.
- `Error  out  1`: qualifies Done.
- `ErrMisalign  out  1`: error cause is misalignment.
- `LoadResult  out  DATA_WIDTH`: extended load data.
- `MemReq  out  1`: memory request.
- `MemWE  out  1`: memory write enable.
- `MemAddr  out  ADDR_WIDTH`: memory address.
- `MemByteEn  out  DATA_WIDTH/8`: memory byte enables.
- `MemWData  out  DATA_WIDTH`: memory write data.
- `MemAck  in  1`: memory acknowledge.
- `MemRData  in  DATA_WIDTH`: memory read data.

Function
REQ-007 Operation codes SHALL be: 0 lb, 1 lh, 2 lw, 3 lbu, 4 lhu, 5 sb, 6 sh, 7 sw.
REQ-008 The effective address SHALL be SrcA+Imm, computed modulo 2^ADDR_WIDTH with no carry-out retained.
REQ-009 The FSM SHALL have three states, IDLE, ACCESS and DONE, with these transitions:
- IDLE→ACCESS: Start=1 and the access is aligned.
- IDLE→DONE: Start=1 and the access is misaligned.
- ACCESS→DONE: MemAck=1, or the timeout expires.
- DONE→IDLE: always.
REQ-010 In IDLE with Start=1, the block SHALL register the opcode, effective address and WriteData; operands in other states are ignored.
REQ-011 Busy SHALL be 1 in ACCESS and DONE, and Start SHALL be ignored while Busy=1.
REQ-012 Alignment SHALL be defined as:
- lh, lhu and sh: address bit 0 = 0.
- lw and sw: address bits [1:0] = 0.
- Byte operations: always aligned.
REQ-013 A misaligned access SHALL raise no MemReq and SHALL produce Done=1, Error=1 and ErrMisalign=1 in the cycle after Start.
REQ-014 In ACCESS, MemReq SHALL be 1 and MemAddr, MemWE, MemByteEn and MemWData SHALL be stable until the cycle MemAck=1 is sampled.
REQ-015 MemAddr SHALL be the effective address with the low log2(DATA_WIDTH/8) bits cleared.
REQ-016 MemByteEn SHALL select 1, 2 or 4 contiguous lanes starting at lane addr[log2(DATA_WIDTH/8)-1:0].
- Loads drive MemByteEn the same way as stores.
- MemWE=1 only for opcodes 5, 6 and 7.
REQ-017 MemWData SHALL replicate the low byte (sb), low halfword (sh) or low word (sw) of WriteData across all lanes.
REQ-018 On MemAck for a load, the block SHALL extract the addressed lane(s) from MemRData and extend them to DATA_WIDTH into LoadResult.
- Sign-extend for lb, lh and lw.
- Zero-extend for lbu and lhu.
REQ-019 LoadResult SHALL hold its value until the next load completes, and SHALL be unchanged by stores and errors.
REQ-020 A cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without MemAck.
REQ-021 When the counter reaches TIMEOUT-1 without MemAck, the block SHALL drop MemReq, go to DONE, and assert Error=1 with ErrMisalign=0.
REQ-022 If MemAck=1 in the same cycle the timeout would fire, MemAck SHALL take priority and the access completes normally.
REQ-023 Done SHALL be high exactly one cycle (state DONE), and Error and ErrMisalign are valid only while Done=1.
REQ-024 Minimum latency SHALL be: Start at cycle 0, MemReq at cycle 1, MemAck at cycle 1, Done at cycle 2.
REQ-025 MemAck sampled outside ACCESS SHALL be ignored.

Reset
REQ-026 While rst=1, the state SHALL be IDLE and the counter 0.
REQ-027 While rst=1, Busy, Done, Error, ErrMisalign, MemReq and MemWE SHALL be 0, and LoadResult, MemAddr, MemByteEn and MemWData SHALL be all zeros.
REQ-028 Reset asserted mid-ACCESS SHALL drop MemReq immediately, without waiting for a clock edge, and SHALL produce no Done.

Structure
REQ-029 The operation-code enum, state enum and alignment-check function SHALL live in the shared package lsu_pkg.
REQ-030 Lane extraction and extension SHALL be a combinational sub-module load_extend, parametrised by DATA_WIDTH.

Verification
REQ-031 The bench SHALL cover an lb sign case:
- Stimulus: SrcA=0x100, Imm=3, MemRData=0x80FF_FF00, MemAck in the first ACCESS cycle.
- Required: MemByteEn=0b1000, LoadResult=0xFFFF_FF80, Done at cycle 2.
REQ-032 The bench SHALL cover an lhu with address wrap:
- Stimulus: SrcA=0xFFFF_FFFE, Imm=4, MemRData=0xBEEF_1234.
- Required: MemAddr=0x0000_0000, MemByteEn=0b1100, LoadResult=0x0000_BEEF.
REQ-033 The bench SHALL cover sh with a delayed MemAck:
- Stimulus: WriteData=0x1234_ABCD, address 0x202, MemAck after 3 cycles.
- Required: MemWData=0xABCD_ABCD, MemByteEn=0b1100, MemReq held 4 cycles, LoadResult unchanged.
REQ-034 The bench SHALL cover a misaligned lw:
- Stimulus: lw at address 0x101.
- Required: no MemReq; Done=Error=ErrMisalign=1 at cycle 1.
REQ-035 The bench SHALL cover timeout and ack priority:
- Stimulus: TIMEOUT=4 with MemAck never asserted.
- Required: MemReq for 4 cycles, then Done=1, Error=1, ErrMisalign=0.
- Stimulus: repeat with MemAck in the 4th cycle.
- Required: Error=0.
REQ-036 The bench SHALL cover reset mid-operation and Start while busy:
- Stimulus: rst asserted in ACCESS.
- Required: MemReq=0 before the next edge, and no Done.
- Stimulus: Start pulsed while Busy=1.
- Required: no second access issued.
